// File: rtl/scan_decoder.sv
// Registered one-hot (or one-cold) decoder with enable/blanking and an
// auto-scan mode that walks the active output from 0 up to a programmable last index.
module scan_decoder #(
  parameter int SEL_W      = 4,
  parameter int DIV_W      = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    sel_load,
  input  logic [DIV_W-1:0]        div,
  input  logic [SEL_W-1:0]        last,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    wrap,
  output logic                    valid
);

  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] ONE_HOT_BASE = OUT_W'(1);
  localparam logic [OUT_W-1:0] INACTIVE     = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             valid_q, valid_d;
  logic             mode_q, mode_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] decoded;

  always_comb begin
    cur_sel_d = cur_sel_q;
    presc_d   = presc_q;
    wrap_d    = 1'b0;
    valid_d   = 1'b0;
    mode_d    = mode_q;
    decoded   = '0;
    out_d     = INACTIVE;

    // Disabled: everything frozen (including the mode history) and outputs blanked.
    if (en) begin
      valid_d = 1'b1;
      mode_d  = mode;
      if (sel_load) begin
        cur_sel_d = sel_in;
        presc_d   = '0;
      end else if (mode != mode_q || !mode) begin
        presc_d = '0;
      end else if (presc_q == div) begin
        presc_d = '0;
        if (cur_sel_q >= last) begin
          cur_sel_d = '0;
          wrap_d    = 1'b1;
        end else begin
          cur_sel_d = cur_sel_q + SEL_W'(1);
        end
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end

      // The output is decoded from the next select so it changes on the same edge.
      decoded = ONE_HOT_BASE << cur_sel_d;
      out_d   = (ACTIVE_LOW != 0) ? ~decoded : decoded;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel_q <= '0;
      presc_q   <= '0;
      wrap_q    <= 1'b0;
      valid_q   <= 1'b0;
      mode_q    <= 1'b0;
      out_q     <= INACTIVE;
    end else begin
      cur_sel_q <= cur_sel_d;
      presc_q   <= presc_d;
      wrap_q    <= wrap_d;
      valid_q   <= valid_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
    end
  end

  assign out     = out_q;
  assign cur_sel = cur_sel_q;
  assign wrap    = wrap_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: active-high and active-low instances share
// the same stimulus; every expectation is hand-computed.
module tb_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [3:0]  sel_in;
  logic        sel_load;
  logic [15:0] div;
  logic [3:0]  last;

  logic [15:0] out, out_al;
  logic [3:0]  cur_sel, cur_sel_al;
  logic        wrap, wrap_al;
  logic        valid, valid_al;

  int passed = 0;
  int total  = 0;

  scan_decoder #(.SEL_W(4), .DIV_W(16), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .sel_load(sel_load), .div(div), .last(last), .out(out),
    .cur_sel(cur_sel), .wrap(wrap), .valid(valid)
  );

  scan_decoder #(.SEL_W(4), .DIV_W(16), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .sel_load(sel_load), .div(div), .last(last), .out(out_al),
    .cur_sel(cur_sel_al), .wrap(wrap_al), .valid(valid_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge, and inputs are driven there as well.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel_in = 4'd0; sel_load = 1'b0;
    div = 16'd0; last = 4'd0;
    step();
    step();
    total++; if (out !== 16'h0000) $display("[TB] FAIL reset_out: got %h want %h", out, 16'h0000); else passed++;
    total++; if (cur_sel !== 4'd0) $display("[TB] FAIL reset_cur_sel: got %0d want 0", cur_sel); else passed++;
    total++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", valid); else passed++;
    total++; if (wrap !== 1'b0) $display("[TB] FAIL reset_wrap: got %b want 0", wrap); else passed++;
    total++; if (out_al !== 16'hFFFF) $display("[TB] FAIL reset_out_al: got %h want %h", out_al, 16'hFFFF); else passed++;
    rst_n = 1'b1;
    step();
    total++; if (cur_sel !== 4'd0) $display("[TB] FAIL release_cur_sel: got %0d want 0", cur_sel); else passed++;
    total++; if (out !== 16'h0001) $display("[TB] FAIL release_out: got %h want %h", out, 16'h0001); else passed++;
    total++; if (valid !== 1'b1) $display("[TB] FAIL release_valid: got %b want 1", valid); else passed++;
    total++; if (out_al !== 16'hFFFE) $display("[TB] FAIL release_out_al: got %h want %h", out_al, 16'hFFFE); else passed++;
  endtask

  task automatic test_direct_load();
    sel_in = 4'hB; sel_load = 1'b1;
    step();
    sel_load = 1'b0; sel_in = 4'h3;
    total++; if (cur_sel !== 4'd11) $display("[TB] FAIL load_cur_sel: got %0d want 11", cur_sel); else passed++;
    total++; if (out !== 16'h0800) $display("[TB] FAIL load_out: got %h want %h", out, 16'h0800); else passed++;
    total++; if (out_al !== 16'hF7FF) $display("[TB] FAIL load_out_al: got %h want %h", out_al, 16'hF7FF); else passed++;
    step();
    total++; if (cur_sel !== 4'd11) $display("[TB] FAIL direct_hold: got %0d want 11", cur_sel); else passed++;
    total++; if (wrap !== 1'b0) $display("[TB] FAIL direct_wrap: got %b want 0", wrap); else passed++;
  endtask

  task automatic test_scan();
    logic [3:0]  exp_cur;
    logic        exp_wrap;
    logic [15:0] exp_out;
    sel_in = 4'd0; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    mode = 1'b1; div = 16'd2; last = 4'd3;
    step();
    total++; if (cur_sel !== 4'd0) $display("[TB] FAIL scan_entry_cur: got %0d want 0", cur_sel); else passed++;
    // Each value is held 3 edges after entry; the 3->0 step lands on edge 12.
    for (int k = 1; k <= 13; k++) begin
      step();
      exp_cur  = 4'((k / 3) % 4);
      exp_wrap = (k == 12);
      exp_out  = 16'h0001 << exp_cur;
      total++; if (cur_sel !== exp_cur) $display("[TB] FAIL scan_cur k=%0d: got %0d want %0d", k, cur_sel, exp_cur); else passed++;
      total++; if (wrap !== exp_wrap) $display("[TB] FAIL scan_wrap k=%0d: got %b want %b", k, wrap, exp_wrap); else passed++;
      total++; if (out !== exp_out) $display("[TB] FAIL scan_out k=%0d: got %h want %h", k, out, exp_out); else passed++;
    end
  endtask

  task automatic test_load_on_tick();
    step();
    total++; if (cur_sel !== 4'd0) $display("[TB] FAIL pre_tick_cur: got %0d want 0", cur_sel); else passed++;
    sel_in = 4'd2; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    total++; if (cur_sel !== 4'd2) $display("[TB] FAIL tick_load_cur: got %0d want 2", cur_sel); else passed++;
    total++; if (wrap !== 1'b0) $display("[TB] FAIL tick_load_wrap: got %b want 0", wrap); else passed++;
    step();
    total++; if (cur_sel !== 4'd2) $display("[TB] FAIL after_load1: got %0d want 2", cur_sel); else passed++;
    step();
    total++; if (cur_sel !== 4'd2) $display("[TB] FAIL after_load2: got %0d want 2", cur_sel); else passed++;
    step();
    total++; if (cur_sel !== 4'd3) $display("[TB] FAIL after_load3: got %0d want 3", cur_sel); else passed++;
  endtask

  task automatic test_enable();
    sel_in = 4'd1; sel_load = 1'b1;
    step();
    total++; if (cur_sel !== 4'd1) $display("[TB] FAIL en_setup_cur: got %0d want 1", cur_sel); else passed++;
    en = 1'b0; sel_in = 4'd9;
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (out !== 16'h0000) $display("[TB] FAIL dis_out k=%0d: got %h want %h", k, out, 16'h0000); else passed++;
      total++; if (valid !== 1'b0) $display("[TB] FAIL dis_valid k=%0d: got %b want 0", k, valid); else passed++;
      total++; if (cur_sel !== 4'd1) $display("[TB] FAIL dis_cur k=%0d: got %0d want 1", k, cur_sel); else passed++;
      total++; if (out_al !== 16'hFFFF) $display("[TB] FAIL dis_out_al k=%0d: got %h want %h", k, out_al, 16'hFFFF); else passed++;
    end
    en = 1'b1; sel_load = 1'b0;
    step();
    total++; if (out !== 16'h0002) $display("[TB] FAIL reen_out: got %h want %h", out, 16'h0002); else passed++;
    total++; if (valid !== 1'b1) $display("[TB] FAIL reen_valid: got %b want 1", valid); else passed++;
    total++; if (out_al !== 16'hFFFD) $display("[TB] FAIL reen_out_al: got %h want %h", out_al, 16'hFFFD); else passed++;
  endtask

  task automatic test_last_lower();
    div = 16'd0; last = 4'd7; sel_in = 4'd5; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    total++; if (cur_sel !== 4'd5) $display("[TB] FAIL lower_setup: got %0d want 5", cur_sel); else passed++;
    last = 4'd2;
    step();
    total++; if (cur_sel !== 4'd0) $display("[TB] FAIL lower_cur: got %0d want 0", cur_sel); else passed++;
    total++; if (wrap !== 1'b1) $display("[TB] FAIL lower_wrap: got %b want 1", wrap); else passed++;
    total++; if (out !== 16'h0001) $display("[TB] FAIL lower_out: got %h want %h", out, 16'h0001); else passed++;
    step();
    total++; if (cur_sel !== 4'd1) $display("[TB] FAIL lower_next_cur: got %0d want 1", cur_sel); else passed++;
    total++; if (wrap !== 1'b0) $display("[TB] FAIL lower_next_wrap: got %b want 0", wrap); else passed++;
    last = 4'd0;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (cur_sel !== 4'd0) $display("[TB] FAIL last0_cur k=%0d: got %0d want 0", k, cur_sel); else passed++;
      total++; if (wrap !== 1'b1) $display("[TB] FAIL last0_wrap k=%0d: got %b want 1", k, wrap); else passed++;
    end
  endtask

  task automatic test_mode_exit();
    last = 4'd7; sel_in = 4'd6; sel_load = 1'b1;
    step();
    sel_load = 1'b0; mode = 1'b0;
    step();
    total++; if (cur_sel !== 4'd6) $display("[TB] FAIL mode_exit_cur: got %0d want 6", cur_sel); else passed++;
    step();
    total++; if (wrap !== 1'b0) $display("[TB] FAIL mode_exit_wrap: got %b want 0", wrap); else passed++;
    total++; if (out !== 16'h0040) $display("[TB] FAIL mode_exit_out: got %h want %h", out, 16'h0040); else passed++;
  endtask

  task automatic test_async_reset();
    mode = 1'b1; div = 16'd0; last = 4'd7;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (out !== 16'h0000) $display("[TB] FAIL async_out: got %h want %h", out, 16'h0000); else passed++;
    total++; if (cur_sel !== 4'd0) $display("[TB] FAIL async_cur: got %0d want 0", cur_sel); else passed++;
    total++; if (valid !== 1'b0) $display("[TB] FAIL async_valid: got %b want 0", valid); else passed++;
    total++; if (out_al !== 16'hFFFF) $display("[TB] FAIL async_out_al: got %h want %h", out_al, 16'hFFFF); else passed++;
    #2;
    rst_n = 1'b1; mode = 1'b0;
    step();
    total++; if (out !== 16'h0001) $display("[TB] FAIL async_release_out: got %h want %h", out, 16'h0001); else passed++;
  endtask

  initial begin
    test_reset();
    test_direct_load();
    test_scan();
    test_load_on_tick();
    test_enable();
    test_last_lower();
    test_mode_exit();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered one-hot decoder. Generalises the fixed 4-to-16 combinational decoder to SEL_W-bit select and 2^SEL_W outputs.
- Adds a registered output, an enable/blanking control and an auto-scan mode. In auto-scan mode an internal counter walks the active output 0..last at a programmable rate.
- Intended for multiplexed display digit drive and row/strobe generation, fed from board-level control logic.

Parameters:
- SEL_W, 4, select width; output width is OUT_W = 2^SEL_W.
- DIV_W, 16, prescaler width; sets the maximum scan period.
- ACTIVE_LOW, 0, 1 inverts every bit of out. The active output is then 0 and inactive outputs are 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- en  input  1  1 = outputs driven; 0 = all outputs inactive and state frozen.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- sel_in  input  SEL_W  select value to load.
- sel_load  input  1  single-cycle strobe: load sel_in into cur_sel.
- div  input  DIV_W  scan period minus one, in clk cycles.
- last  input  SEL_W  highest index visited in scan mode.
- out  output  OUT_W  registered one-hot (or one-cold if ACTIVE_LOW) decode of cur_sel.
- cur_sel  output  SEL_W  current select register.
- wrap  output  1  one-cycle pulse when the scan wraps from last to 0.
- valid  output  1  registered copy of en; 1 when out carries a live decode.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cur_sel=0, prescaler=0, wrap=0, valid=0.
  - out = all inactive: all 0s, or all 1s when ACTIVE_LOW=1.
  - On release, the first edge behaves per the normal rules below.
- Registered output:
  - out and valid are updated on the same edge as cur_sel.
  - out reflects the decode of the new cur_sel and the current en.
  - Latency from any change to the visible out change is 1 clk.
  - Exactly one bit of out is active whenever valid=1; none is active when valid=0.
- en=0:
  - On the next edge out goes all inactive and valid becomes 0.
  - cur_sel and the prescaler hold, sel_load is ignored, and wrap is 0.
  - When en returns to 1, out shows the held cur_sel one edge later.
- Direct mode (mode=0):
  - With sel_load=1, cur_sel takes sel_in on the edge; otherwise cur_sel holds.
  - The prescaler is held at 0 and wrap is always 0.
- Scan mode (mode=1):
  - The prescaler counts 0..div. On an edge where prescaler==div, a tick occurs and the prescaler returns to 0. Otherwise the prescaler increments.
  - On a tick, if cur_sel >= last, then cur_sel is set to 0 and wrap=1 for that one cycle. Otherwise cur_sel increments by 1.
  - div=0 gives one step per clk. last=0 holds cur_sel at 0 and pulses wrap on every tick.
  - If cur_sel > last (for example, last was lowered), the next tick sends cur_sel to 0 and pulses wrap.
  - With last = OUT_W-1 the scan covers all outputs. No index beyond OUT_W-1 can exist.
  - The step period is div+1 clks.
- Simultaneous events, in priority order:
  - rst_n.
  - en=0.
  - sel_load: loads sel_in, clears the prescaler to 0 and suppresses both the tick and wrap on that edge.
  - tick.
- Mode changes:
  - Any edge on which mode differs from its previous registered value clears the prescaler. No tick occurs on that edge.
  - cur_sel is kept across the change.
  - Scan resumes from the kept cur_sel; the first step comes div+1 clks after entry.
- div changes mid-count:
  - A new div takes effect immediately in the compare.
  - If the prescaler is already above the new div, it continues to wrap at 2^DIV_W back to 0. Software must use sel_load or a mode toggle to resync.

Test Plan:
- Reset release, SEL_W=4, en=1, mode=0, no load -> cur_sel=0, out=16'h0001 from the first edge, valid=1.
- Direct mode, sel_load with sel_in=4'hB -> next edge cur_sel=11, out=16'h0800. With ACTIVE_LOW=1, out=16'hF7FF.
- Scan, div=2, last=3 -> cur_sel sequence 0,1,2,3,0 with each value held 3 clks; wrap high for exactly 1 clk at each 3->0 step.
- Scan, sel_load (sel_in=2) on a tick edge -> cur_sel=2, no increment, wrap=0; the next step occurs 3 clks later.
- en deasserted for 5 clks mid-scan at cur_sel=1 -> out=0 and valid=0 during that time; cur_sel stays 1; on re-enable out=16'h0002 after 1 edge.
- Scan with last lowered from 7 to 2 while cur_sel=5, div=0 -> next edge cur_sel=0 with a wrap pulse. Reset asserted mid-scan -> immediate (asynchronous) out=0, cur_sel=0, without waiting for clk.
